// File: rtl/aes_pkg.sv
// Shared AES definitions: key width, round-key count and the
// re-key controller state encoding.
package aes_pkg;

    localparam int AES_KEY_W      = 128;
    localparam int NUM_ROUND_KEYS = 11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRAIN  = 3'd1,
        S_LOAD   = 3'd2,
        S_SETTLE = 3'd3,
        S_WAIT   = 3'd4
    } ks_state_e;

endpackage

// File: rtl/aes_key_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after the
// pointer (wrapping) wins; one-hot grant plus its index.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW-1:0] w_pos;

    // scan from the pointer upward; the first hit is kept
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_pos = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = IW'((int'(i_ptr) + k) % N);
            if (!o_any && i_req[w_pos]) begin
                o_any        = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = w_pos;
            end
        end
    end

endmodule

// File: rtl/aes_key_ctrl.sv
// Re-key controller: arbitrates key loads, drains the cipher pipe,
// drives the key scheduler and reports done/err/ownership.
module aes_key_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 64,
    parameter int ID_W    = 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*AES_KEY_W-1:0]   req_key,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             req_done,
    output logic [NUM_REQ-1:0]             req_err,
    input  logic                           pipe_empty,
    output logic                           pipe_hold,
    output logic                           key_valid,
    output logic [ID_W-1:0]                key_owner,
    output logic                           ks_load_key,
    output logic [AES_KEY_W-1:0]           ks_key_in,
    input  logic                           ks_busy,
    input  logic                           ks_keys_ready
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    ks_state_e            r_state;
    ks_state_e            w_next;
    logic [TMR_W-1:0]     r_timer;
    logic [ID_W-1:0]      r_ptr;
    logic [ID_W-1:0]      r_gid;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   w_gnt;
    logic [ID_W-1:0]      w_gidx;
    logic                 w_any;
    logic                 w_timeout;
    logic [AES_KEY_W-1:0] w_key;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gidx),
        .o_any (w_any)
    );

    assign w_timeout = (r_timer == TMR_W'(TIMEOUT - 1));

    // select the winning requester's key
    always_comb begin
        w_key = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gnt[k]) begin
                w_key = req_key[k*AES_KEY_W +: AES_KEY_W];
            end
        end
    end

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_any) w_next = S_DRAIN;
            S_DRAIN:  if (pipe_empty && !ks_busy) w_next = S_LOAD;
            S_LOAD:   w_next = S_SETTLE;
            S_SETTLE: w_next = S_WAIT;
            S_WAIT:   if (ks_keys_ready || w_timeout) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // state-decoded outputs: hold the pipe for the whole sequence
    always_comb begin
        pipe_hold   = (r_state != S_IDLE);
        ks_load_key = (r_state == S_LOAD);
    end

    // grant bookkeeping, key latch, timer and response pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_ready <= '0;
            req_done  <= '0;
            req_err   <= '0;
            key_valid <= 1'b0;
            key_owner <= '0;
            ks_key_in <= '0;
            r_timer   <= '0;
            r_ptr     <= '0;
            r_gid     <= '0;
            r_gnt     <= '0;
        end else begin
            req_ready <= '0;
            req_done  <= '0;
            req_err   <= '0;
            if (r_state == S_IDLE && w_any) begin
                req_ready <= w_gnt;
                r_gnt     <= w_gnt;
                r_gid     <= w_gidx;
                ks_key_in <= w_key;
                key_valid <= 1'b0;
                if (w_gidx == ID_W'(NUM_REQ - 1)) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= w_gidx + ID_W'(1);
                end
            end
            if (r_state == S_LOAD) begin
                r_timer <= '0;
            end
            if (r_state == S_WAIT) begin
                r_timer <= r_timer + TMR_W'(1);
                if (ks_keys_ready) begin
                    key_owner <= r_gid;
                    key_valid <= 1'b1;
                    req_done  <= r_gnt;
                end else if (w_timeout) begin
                    req_err <= r_gnt;
                end
            end
        end
    end

endmodule
